// File: rtl/spi_inert_serf.sv
// spi_inert_serf: SPI mode-0 slave front end for an inertial sensor model.
// 16-bit frames with an R/W bit, a 7-bit address and 8 data bits. The block
// holds a few control registers and a free-running gyro sample counter that
// captures yaw_smpl and raises a level data-ready interrupt.
// Optional build macro: SERF_YAW_SNAPSHOT_EN. When defined, a read of YAW_L
// latches YAW_H so that the following YAW_H read returns a coherent pair.
module spi_inert_serf #(
    parameter logic [15:0] SMPL_DIV = 16'd1024,
    parameter logic [7:0]  WHO_AM_I = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_smpl
);

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_CTRL5     = 7'h14;
    localparam logic [6:0] ADDR_YAW_L     = 7'h26;
    localparam logic [6:0] ADDR_YAW_H     = 7'h27;

    // Bit [0] is the first sync flop, [1] the second, [2] the edge-detect flop.
    logic [2:0]  ss_sync;
    logic [2:0]  sclk_sync;
    logic [2:0]  mosi_sync;

    logic        ss_fall;
    logic        ss_rise;
    logic        ss_low;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_bit;

    logic [4:0]  bit_cnt;
    logic [15:0] rx;
    logic [15:0] rx_shifted;
    logic [7:0]  tx;
    logic        rd_phase;
    logic        rd_load;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  yaw_hi_rd;
    logic        frame_done;
    logic        wr_commit;
    logic        rd_commit;

    logic [7:0]  int1_ctrl;
    logic [7:0]  ctrl2_g;
    logic [7:0]  ctrl5;
    logic [15:0] yaw;
    logic [15:0] smpl_cnt;
    logic        smpl_run;
    logic        smpl_tick;
    logic        int_set;
    logic        int_clr;
    logic        int_flag;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b000;
            mosi_sync <= 3'b000;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    assign ss_fall    = ss_sync[2] & ~ss_sync[1];
    assign ss_rise    = ~ss_sync[2] & ss_sync[1];
    assign ss_low     = ~ss_sync[1];
    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
    assign mosi_bit   = mosi_sync[2];

    // After 8 bits the R/W flag sits in bit 7 and the address in bits 6:0.
    assign rx_shifted = {rx[14:0], mosi_bit};
    assign rd_addr    = rx_shifted[6:0];
    assign rd_load    = sclk_rise & ss_low & (bit_cnt == 5'd7) & rx_shifted[7];
    assign frame_done = ss_rise & (bit_cnt == 5'd16);
    assign wr_commit  = frame_done & ~rx[15];
    assign rd_commit  = frame_done & rx[15];

`ifdef SERF_YAW_SNAPSHOT_EN
    logic [7:0] yaw_snap;
    logic       yaw_snap_valid;

    // Capture YAW_H when YAW_L is read; the next YAW_H read consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaw_snap       <= 8'h00;
            yaw_snap_valid <= 1'b0;
        end else if (rd_load && rd_addr == ADDR_YAW_L) begin
            yaw_snap       <= yaw[15:8];
            yaw_snap_valid <= 1'b1;
        end else if (rd_load && rd_addr == ADDR_YAW_H) begin
            yaw_snap_valid <= 1'b0;
        end
    end

    assign yaw_hi_rd = yaw_snap_valid ? yaw_snap : yaw[15:8];
`else
    assign yaw_hi_rd = yaw[15:8];
`endif

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_INT1_CTRL: rd_data = int1_ctrl;
            ADDR_WHO_AM_I:  rd_data = WHO_AM_I;
            ADDR_CTRL2_G:   rd_data = ctrl2_g;
            ADDR_CTRL5:     rd_data = ctrl5;
            ADDR_YAW_L:     rd_data = yaw[7:0];
            ADDR_YAW_H:     rd_data = yaw_hi_rd;
            default:        rd_data = 8'h00;
        endcase
    end

    // Frame shifter: collect MOSI on SCLK rises, serve read data on falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 5'd0;
            rx       <= 16'h0000;
            tx       <= 8'h00;
            rd_phase <= 1'b0;
        end else if (ss_fall) begin
            bit_cnt  <= 5'd0;
            rx       <= 16'h0000;
            tx       <= 8'h00;
            rd_phase <= 1'b0;
        end else begin
            if (sclk_rise && ss_low) begin
                rx <= rx_shifted;
                if (bit_cnt != 5'd16) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (rd_load) begin
                tx       <= rd_data;
                rd_phase <= 1'b1;
            end else if (sclk_fall && rd_phase && bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                tx <= {tx[6:0], 1'b0};
            end
            if (ss_rise) begin
                rd_phase <= 1'b0;
            end
        end
    end

    assign MISO = rd_phase & tx[7];

    // Control registers are written only by a complete 16-bit write frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl5     <= 8'h00;
            yaw       <= 16'h0000;
        end else begin
            if (wr_commit) begin
                case (rx[14:8])
                    ADDR_INT1_CTRL: int1_ctrl <= rx[7:0];
                    ADDR_CTRL2_G:   ctrl2_g   <= rx[7:0];
                    ADDR_CTRL5:     ctrl5     <= rx[7:0];
                    default:        ;
                endcase
            end
            if (smpl_tick) begin
                yaw <= yaw_smpl;
            end
        end
    end

    assign smpl_run  = |ctrl2_g[7:4];
    assign smpl_tick = smpl_run && (smpl_cnt == SMPL_DIV - 16'd1);

    // Sample period counter; held at zero while the gyro is powered down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt <= 16'h0000;
        end else if (!smpl_run || smpl_tick) begin
            smpl_cnt <= 16'h0000;
        end else begin
            smpl_cnt <= smpl_cnt + 16'd1;
        end
    end

    // A new sample outranks a simultaneous clear so no data-ready is lost.
    assign int_set = smpl_tick & int1_ctrl[1];
    assign int_clr = (rd_commit && rx[14:8] == ADDR_YAW_H) ||
                     (wr_commit && rx[14:8] == ADDR_INT1_CTRL && !rx[1]);

    // Data-ready interrupt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_flag <= 1'b0;
        end else if (int_set) begin
            int_flag <= 1'b1;
        end else if (int_clr) begin
            int_flag <= 1'b0;
        end
    end

    assign INT = int_flag;

endmodule

// File: tb/tb_spi_inert_serf.sv
// Testbench for spi_inert_serf: directed scenarios plus random frames,
// checked against a transaction-level model of the register file,
// sample timer and interrupt.
`timescale 1ns/1ps
module tb_spi_inert_serf;

    localparam int          DIVI = 400;
    localparam logic [15:0] DIV  = 16'd400;
    localparam int          HP   = 4;     // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        INT;
    logic [15:0] yaw_smpl = 16'h0000;

    spi_inert_serf #(.SMPL_DIV(DIV), .WHO_AM_I(8'h6A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .INT      (INT),
        .yaw_smpl (yaw_smpl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_int = 1'b0;

    // Model state (written by the model process).
    logic [7:0]  m_int1, m_ctrl2, m_ctrl5;
    logic [15:0] m_yaw;
    logic        m_int;
    int          m_phase;
    // Frame bookkeeping (written by the stimulus process).
    int          pend_cyc = -1;
    logic [15:0] pend_word = 16'h0000;
    logic [7:0]  m_snap = 8'h00;
    logic        m_snap_ok = 1'b0;

    // Model: a completed frame takes effect on the 3rd clk edge after SS_n
    // rises; while the gyro is on, a sample lands every DIV clocks.
    initial begin : model
        logic tick, set, clr;
        m_int1 = 0; m_ctrl2 = 0; m_ctrl5 = 0; m_yaw = 0; m_int = 0; m_phase = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_int1 = 0; m_ctrl2 = 0; m_ctrl5 = 0; m_yaw = 0; m_int = 0; m_phase = 0;
            end else begin
                tick = (m_ctrl2[7:4] != 4'h0) && (m_phase == DIVI - 1);
                set  = tick && m_int1[1];
                clr  = 1'b0;
                if (tick) m_yaw = yaw_smpl;
                if (m_ctrl2[7:4] == 4'h0) m_phase = 0;
                else m_phase = (m_phase + 1) % DIVI;
                if (cyc == pend_cyc) begin
                    if (pend_word[15]) begin
                        if (pend_word[14:8] == 7'h27) clr = 1'b1;
                    end else begin
                        case (pend_word[14:8])
                            7'h0D: begin
                                m_int1 = pend_word[7:0];
                                if (!pend_word[1]) clr = 1'b1;
                            end
                            7'h11: m_ctrl2 = pend_word[7:0];
                            7'h14: m_ctrl5 = pend_word[7:0];
                            default: ;
                        endcase
                    end
                end
                m_int = set | (m_int & ~clr);
            end
        end
    end

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        case (a)
            7'h0D:   return m_int1;
            7'h0F:   return 8'h6A;
            7'h11:   return m_ctrl2;
            7'h14:   return m_ctrl5;
            7'h26:   return m_yaw[7:0];
            7'h27:   return m_snap_ok ? m_snap : m_yaw[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // Every-cycle interrupt comparison against the model.
    initial begin : int_compare
        forever begin
            @(negedge clk);
            if (rst_n && chk_int) begin
                total++;
                if (INT !== m_int) begin
                    bad++;
                    $display("FAIL int_track cyc=%0d actual=%0b required=%0b", cyc, INT, m_int);
                end
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end else begin
            $display("ok   %s value=%02h", name, act);
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    // Drive one frame of nbits; got = MISO seen before rises 9..16,
    // exp = model read value at the 8th rise (read frames only).
    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit raise_ss,
                             input bit align, output logic [7:0] got, output logic [7:0] exp);
        got = 8'h00;
        exp = 8'h00;
        SS_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = word[15-i];
            repeat (HP) @(negedge clk);
            if (i >= 8) got[15-i] = MISO;
            SCLK = 1'b1;
            if (i == 7) begin
                repeat (2) @(negedge clk);
                if (word[15]) begin
                    exp = model_rd(word[14:8]);
`ifdef SERF_YAW_SNAPSHOT_EN
                    if (word[14:8] == 7'h26) begin
                        m_snap = m_yaw[15:8];
                        m_snap_ok = 1'b1;
                    end else if (word[14:8] == 7'h27) begin
                        m_snap_ok = 1'b0;
                    end
`endif
                end
                repeat (HP - 2) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        if (raise_ss) begin
            repeat (HP) @(negedge clk);
            if (align) begin
                for (int k = 0; k < 2 * DIVI && m_phase != DIVI - 3; k++) @(negedge clk);
            end
            SS_n = 1'b1;
            if (nbits == 16) begin
                pend_word = word;
                pend_cyc  = cyc + 3;
            end
            repeat (2 * HP) @(negedge clk);
            check8("miso_idle", {7'h00, MISO}, 8'h00);
        end
    endtask

    task automatic read_chk(input string name, input logic [6:0] a, input logic [7:0] lit);
        logic [7:0] got, exp;
        spi_frame({1'b1, a, 8'h00}, 16, 1'b1, 1'b0, got, exp);
        check8({name, "_model"}, got, exp);
        check8(name, got, lit);
    endtask

    task automatic write_frame(input logic [15:0] word, input int nbits);
        logic [7:0] got, exp;
        spi_frame(word, nbits, 1'b1, 1'b0, got, exp);
        if (nbits == 16) check8("wr_miso", got, 8'h00);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] got, exp;
        int t0;

        repeat (3) @(negedge clk);
        check8("rst_int", {7'h00, INT}, 8'h00);
        check8("rst_miso", {7'h00, MISO}, 8'h00);
        rst_n = 1'b1;
        chk_int = 1'b1;
        repeat (2) @(negedge clk);

        // WHO_AM_I read right after reset.
        read_chk("who_am_i", 7'h0F, 8'h6A);
        check8("int_after_whoami", {7'h00, INT}, 8'h00);

        // Aborted CTRL2_G write leaves the gyro off.
        write_frame(16'h1160, 12);
        read_chk("ctrl2_after_abort", 7'h11, 8'h00);
        yaw_smpl = 16'hBEEF;
        repeat (DIVI + 20) @(negedge clk);
        read_chk("yaw_l_no_tick", 7'h26, 8'h00);

        // Enable interrupt and gyro, measure data-ready latency.
        write_frame(16'h0D02, 16);
        yaw_smpl = 16'h1234;
        write_frame(16'h1160, 16);
        t0 = pend_cyc;
        for (int k = 0; k < 3 * DIVI && INT !== 1'b1; k++) @(negedge clk);
        check_val("int_latency", cyc - t0, DIVI);
        read_chk("yaw_l", 7'h26, 8'h34);
        read_chk("yaw_h", 7'h27, 8'h12);
        check8("int_cleared", {7'h00, INT}, 8'h00);

        // Sample tick in the same clk as the YAW_H read completes.
        for (int k = 0; k < 3 * DIVI && INT !== 1'b1; k++) @(negedge clk);
        spi_frame(16'hA700, 16, 1'b1, 1'b1, got, exp);
        check8("tick_vs_clear_rd", got, exp);
        check8("tick_vs_clear_int", {7'h00, INT}, 8'h01);

        // YAW_H coherency across a sample between the two reads.
        yaw_smpl = 16'h00FF;
        @(negedge clk);
        for (int k = 0; k < 2 * DIVI && m_phase != 0; k++) @(negedge clk);
        read_chk("snap_yaw_l", 7'h26, 8'hFF);
        yaw_smpl = 16'h0100;
        @(negedge clk);
        for (int k = 0; k < 2 * DIVI && m_phase != 0; k++) @(negedge clk);
`ifdef SERF_YAW_SNAPSHOT_EN
        read_chk("snap_yaw_h", 7'h27, 8'h00);
`else
        read_chk("snap_yaw_h", 7'h27, 8'h01);
`endif

        // Reset in the middle of a read frame.
        spi_frame(16'h8F00, 9, 1'b0, 1'b0, got, exp);
        rst_n = 1'b0;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        m_snap_ok = 1'b0;
        repeat (3) @(negedge clk);
        check8("midrst_int", {7'h00, INT}, 8'h00);
        check8("midrst_miso", {7'h00, MISO}, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        read_chk("post_rst_whoami", 7'h0F, 8'h6A);
        read_chk("post_rst_ctrl2", 7'h11, 8'h00);

        // Random frames against the model.
        for (int n = 0; n < 40; n++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] d;
            int         nb;
            bit         al;
            case ($urandom_range(0, 7))
                0: a = 7'h0D;
                1: a = 7'h0F;
                2: a = 7'h11;
                3: a = 7'h14;
                4: a = 7'h26;
                5: a = 7'h27;
                default: a = 7'($urandom);
            endcase
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (a == 7'h11 && !rw) d[7:4] = 4'($urandom_range(1, 15));
            if (a == 7'h0D && !rw) d[1] = 1'($urandom_range(0, 3) != 0);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : 16;
            al = (m_ctrl2[7:4] != 4'h0) && ($urandom_range(0, 5) == 0);
            yaw_smpl = 16'($urandom);
            spi_frame({rw, a, d}, nb, 1'b1, al, got, exp);
            if (nb == 16) begin
                if (rw) check8("rnd_rd", got, exp);
                else    check8("rnd_wr_miso", got, 8'h00);
            end
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_inert_serf.md
SPI_INERT_SERF -- requirements
Module: spi_inert_serf

Interface
REQ-001 Parameter: SMPL_DIV, default 16'd1024, number of clk cycles between gyro samples while the gyro is enabled.
REQ-002 Parameter: WHO_AM_I, default 8'h6A, constant returned by a read of address 0x0F.
REQ-003 clk  input  1  system clock; all logic is on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SS_n  input  1  SPI slave select, active-low, asynchronous to clk.
REQ-006 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 MOSI  input  1  SPI data from the monarch, MSB first.
REQ-008 MISO  output  1  SPI data to the monarch, MSB first.
REQ-009 INT  output  1  data-ready interrupt, active-high, level.
REQ-010 yaw_smpl  input  16  signed yaw rate captured at each sample tick.

Function
REQ-011 SS_n, SCLK and MOSI shall each pass through 2 sync flops plus 1 edge-detect flop; SCLK rise/fall and SS_n fall/rise are 1-clk pulses derived from the synced signals.
REQ-012 The SPI frame shall be 16 bits: bit15 R/W (1=read), bits14:8 address, bits7:0 write data or don't-care.
REQ-013 A synced SS_n fall shall clear the 5-bit bit counter and the 16-bit rx shift register.
REQ-014 Each synced SCLK rise while SS_n is low shall shift MOSI into rx LSB and increment the bit counter, saturating at 16.
REQ-015 On the 8th SCLK rise, if rx[7]=1 (R/W bit), the addressed register value shall load an 8-bit tx shift register, and MISO shall show tx[7] in the same cycle.
REQ-016 On SCLK falls after the 9th through 15th rises, tx shall shift left by one, zero-filling; MISO shall be 0 whenever no read data phase is active.
REQ-017 A synced SS_n rise with bit counter==16 and R/W=0 shall commit the write; a write with fewer than 16 bits shall be discarded with no side effect.
REQ-018 Writable registers: 0x0D INT1_CTRL, 0x11 CTRL2_G, 0x14 CTRL5; writes to other addresses shall be ignored.
REQ-019 Readable registers: 0x0D, 0x0F (WHO_AM_I), 0x11, 0x14, 0x26 YAW_L, 0x27 YAW_H; other addresses shall read 8'h00.
REQ-020 The 16-bit sample counter shall run only while CTRL2_G[7:4]!=0, and shall clear and hold at 0 otherwise.
REQ-021 At counter==SMPL_DIV-1 the counter shall wrap to 0 and the block shall capture yaw_smpl into {YAW_H,YAW_L} (sample tick).
REQ-022 A sample tick with INT1_CTRL[1]=1 shall set INT on the next clk; INT shall stay high until cleared.
REQ-023 A completed 16-bit read of 0x27 (SS_n rise, count==16) shall clear INT.
REQ-024 A sample tick and an INT clear in the same cycle shall leave INT set.
REQ-025 A sample tick during a read shall not alter the tx shift register already loaded.
REQ-026 SS_n rising before count==16 (abort) shall leave the registers and INT unchanged.
REQ-027 Writing INT1_CTRL[1]=0 shall clear INT at commit.

Reset
REQ-028 Reset shall clear the synchronizer flops (SS_n syncs to 1, others to 0), the bit counter, rx, tx, INT1_CTRL, CTRL2_G, CTRL5, YAW_H, YAW_L and the sample counter, and drive MISO=0 and INT=0.
REQ-029 Reset asserted mid-frame shall drop the frame; after release, the next SS_n fall starts a clean frame.

Configuration
REQ-030 Macro SERF_YAW_SNAPSHOT_EN defined: a read frame of 0x26 shall latch YAW_H into an 8-bit snapshot at the 8th rise, and the next read of 0x27 shall return the snapshot.
REQ-031 Macro SERF_YAW_SNAPSHOT_EN undefined: a read of 0x27 shall return the live YAW_H, and no snapshot flop shall exist.

Verification
REQ-032 Reset, then frame 16'h8F00 -> MISO bits 8-15 = 8'h6A; INT=0.
REQ-033 Frames 16'h0D02 then 16'h1160, yaw_smpl=16'h1234 -> INT high SMPL_DIV(+1) clks after CTRL2_G commit; read 0x26 -> 8'h34, then 0x27 -> 8'h12, and INT low after the 0x27 SS_n rise.
REQ-034 Write 16'h1160 aborted after 12 SCLKs -> read 0x11 returns 8'h00; no sample ticks occur.
REQ-035 Sample tick forced in the same clk as the 0x27 read completes -> INT stays 1.
REQ-036 With SERF_YAW_SNAPSHOT_EN: read 0x26 (yaw 16'h00FF), tick with yaw 16'h0100, then read 0x27 -> 8'h00; without the macro -> 8'h01.
